tdc_frame_sequencer: RTL and testbench

- Upstream feeder of the histogram builder (hisBuilderFSM) in the dToF pipeline.
- Accepts one acquisition's worth of parallel per-pixel TDC timestamps and serializes it into the builder's wrEn/data stream: one slot per pixel per cycle, pixel-major within an acquisition, ACQ_NUM acquisitions per measurement.
- Marks end of measurement so the builder's peak results can be sampled.

---
 rtl/tdc_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_tdc_frame_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tdc_frame_sequencer.sv
// Serializes one parallel frame of per-pixel TDC timestamps per acquisition into the histogram builder's wrEn/data slot stream.
// Optional timestamp range gate: define TDC_RANGE_GATE_EN (uses GATE_LO/GATE_HI, inclusive).
module tdc_frame_sequencer #(
  parameter int NP        = 10,
  parameter int PIXEL_NUM = 6,
  parameter int ACQ_NUM   = 2,
`ifdef TDC_RANGE_GATE_EN
  parameter int GATE_LO   = 0,
  parameter int GATE_HI   = 1023,
`endif
  localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
  localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    start,
  input  logic                    acq_valid,
  output logic                    acq_ready,
  input  logic [PIXEL_NUM*NP-1:0] hit_data,
  input  logic [PIXEL_NUM-1:0]    hit_mask,
  output logic                    wrEn,
  output logic [NP-1:0]           data,
  output logic [PW-1:0]           pix_idx,
  output logic [AW-1:0]           acq_idx,
  output logic                    busy,
  output logic                    meas_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACQ = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [PW-1:0] LAST_SLOT = PW'(PIXEL_NUM - 1);
  localparam logic [AW-1:0] LAST_ACQ  = AW'(ACQ_NUM - 1);

  state_t                  state_q, state_d;
  logic [AW-1:0]           acq_cnt_q, acq_cnt_d;
  logic [PW-1:0]           slot_q, slot_d;
  logic [PIXEL_NUM*NP-1:0] hit_q, hit_d;
  logic [PIXEL_NUM-1:0]    mask_q, mask_d;
  logic                    wr_en_q, wr_en_d;
  logic [NP-1:0]           data_q, data_d;
  logic [PW-1:0]           pix_q, pix_d;
  logic [AW-1:0]           acq_idx_q, acq_idx_d;
  logic [NP-1:0]           cur_hit_s;
  logic                    accept_s;

  // Current slot's shadowed timestamp and whether it becomes a builder write.
  always_comb begin
    cur_hit_s = hit_q[slot_q*NP +: NP];
`ifdef TDC_RANGE_GATE_EN
    accept_s  = mask_q[slot_q] && (cur_hit_s >= NP'(GATE_LO)) && (cur_hit_s <= NP'(GATE_HI));
`else
    accept_s  = mask_q[slot_q];
`endif
  end

  // Next-state and next-output logic; wrEn/data fall to zero outside SHIFT.
  always_comb begin
    state_d   = state_q;
    acq_cnt_d = acq_cnt_q;
    slot_d    = slot_q;
    hit_d     = hit_q;
    mask_d    = mask_q;
    wr_en_d   = 1'b0;
    data_d    = '0;
    pix_d     = pix_q;
    acq_idx_d = acq_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT_ACQ;
          acq_cnt_d = '0;
        end else begin
          state_d   = IDLE;
        end
      end
      WAIT_ACQ: begin
        if (acq_valid) begin
          hit_d   = hit_data;
          mask_d  = hit_mask;
          slot_d  = '0;
          state_d = SHIFT;
        end else begin
          state_d = WAIT_ACQ;
        end
      end
      SHIFT: begin
        wr_en_d   = accept_s;
        data_d    = accept_s ? cur_hit_s : '0;
        pix_d     = slot_q;
        acq_idx_d = acq_cnt_q;
        if (slot_q == LAST_SLOT) begin
          slot_d = '0;
          // Masked and gated pixels still consume their slot, so frame length is fixed.
          if (acq_cnt_q == LAST_ACQ) begin
            acq_cnt_d = '0;
            state_d   = DONE;
          end else begin
            acq_cnt_d = acq_cnt_q + 1'b1;
            state_d   = WAIT_ACQ;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, shadow frame and registered slot outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      acq_cnt_q <= '0;
      slot_q    <= '0;
      hit_q     <= '0;
      mask_q    <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      pix_q     <= '0;
      acq_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      acq_cnt_q <= acq_cnt_d;
      slot_q    <= slot_d;
      hit_q     <= hit_d;
      mask_q    <= mask_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      pix_q     <= pix_d;
      acq_idx_q <= acq_idx_d;
    end
  end

  assign wrEn      = wr_en_q;
  assign data      = data_q;
  assign pix_idx   = pix_q;
  assign acq_idx   = acq_idx_q;
  assign acq_ready = (state_q == WAIT_ACQ);
  assign busy      = (state_q != IDLE);
  assign meas_done = (state_q == DONE);

endmodule

// File: tb/tb_tdc_frame_sequencer.sv
// Randomized bench for tdc_frame_sequencer against a slot-schedule reference model.
module tb_tdc_frame_sequencer;
  localparam int NP    = 10;
  localparam int PIX   = 6;
  localparam int ACQ   = 2;
  localparam int PW    = 3;
  localparam int AW    = 1;
  localparam int NEVER = 32'h7fff_ffff;
`ifdef TDC_RANGE_GATE_EN
  localparam int G_LO  = 100;
  localparam int G_HI  = 900;
`endif

  logic              clk = 1'b0;
  logic              res, start, acq_valid, acq_ready, wrEn, busy, meas_done;
  logic [PIX*NP-1:0] hit_data;
  logic [PIX-1:0]    hit_mask;
  logic [NP-1:0]     data;
  logic [PW-1:0]     pix_idx;
  logic [AW-1:0]     acq_idx;

  always #5 clk = ~clk;

  tdc_frame_sequencer #(
    .NP(NP), .PIXEL_NUM(PIX), .ACQ_NUM(ACQ)
`ifdef TDC_RANGE_GATE_EN
    , .GATE_LO(G_LO), .GATE_HI(G_HI)
`endif
  ) dut (
    .clk(clk), .res(res), .start(start), .acq_valid(acq_valid), .acq_ready(acq_ready),
    .hit_data(hit_data), .hit_mask(hit_mask), .wrEn(wrEn), .data(data),
    .pix_idx(pix_idx), .acq_idx(acq_idx), .busy(busy), .meas_done(meas_done)
  );

  typedef struct { int cyc; bit wr; int dat; int pix; int acq; } slot_t;
  slot_t slots[$];
  int    caps[$];
  int    cyc, idle_from, ready_from, done_cycle, rst_cycle, frames;
  bit    active, chk_en, captured;
  int    n_cmp, n_bad;
  int    fa[PIX], fb[PIX], fc[PIX], fd[PIX];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [PIX*NP-1:0] pack(input int v[PIX]);
    logic [PIX*NP-1:0] r;
    for (int i = 0; i < PIX; i++) r[i*NP +: NP] = NP'(v[i]);
    return r;
  endfunction

  function automatic logic [PIX*NP-1:0] rnd_data();
    int corner[6];
    int v[PIX];
    corner = '{0, 99, 100, 900, 901, 1023};
    for (int i = 0; i < PIX; i++)
      v[i] = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : int'($urandom_range(0, 1023));
    return pack(v);
  endfunction

  // Reference: one edge's effect on the expected slot schedule.
  task automatic model_edge(input bit s, input bit r, input bit v,
                            input logic [PIX*NP-1:0] d, input logic [PIX-1:0] m);
    int e;
    e = cyc;
    captured = 1'b0;
    if (r) begin
      slots.delete();
      active = 1'b0; idle_from = e; done_cycle = -1; rst_cycle = e;
    end else if (!active && s && (e - 1) >= idle_from) begin
      active = 1'b1; frames = 0; ready_from = e; idle_from = NEVER;
    end else if (active && v && (e - 1) >= ready_from) begin
      for (int c = 0; c < PIX; c++) begin
        slot_t sl;
        int ts;
        bit ok;
        ts = int'(d[c*NP +: NP]);
        ok = m[c];
`ifdef TDC_RANGE_GATE_EN
        ok = ok && (ts >= G_LO) && (ts <= G_HI);
`endif
        sl.cyc = e + 1 + c; sl.wr = ok; sl.dat = ok ? ts : 0; sl.pix = c; sl.acq = frames;
        slots.push_back(sl);
      end
      caps.push_back(e);
      captured = 1'b1;
      frames++;
      ready_from = e + PIX;
      if (frames == ACQ) begin
        active = 1'b0; done_cycle = e + PIX; idle_from = e + PIX + 1;
      end
    end
  endtask

  task automatic check_cycle();
    logic        exp_wr;
    int          exp_dat;
    bit          here;
    exp_wr = 1'b0; exp_dat = 0; here = 1'b0;
    if (slots.size() > 0 && slots[0].cyc == cyc) begin
      here = 1'b1; exp_wr = slots[0].wr; exp_dat = slots[0].dat;
    end
    check_val("wrEn", wrEn, exp_wr);
    check_val("data", data, exp_dat);
    check_val("busy", busy, cyc < idle_from);
    check_val("acq_ready", acq_ready, active && cyc >= ready_from);
    check_val("meas_done", meas_done, cyc == done_cycle);
    if (here) begin
      check_val("pix_idx", pix_idx, slots[0].pix);
      check_val("acq_idx", acq_idx, slots[0].acq);
      void'(slots.pop_front());
    end
    if (cyc == rst_cycle) begin
      check_val("rst_pix_idx", pix_idx, 0);
      check_val("rst_acq_idx", acq_idx, 0);
    end
  endtask

  task automatic step(input bit s, input bit r, input bit v,
                      input logic [PIX*NP-1:0] d, input logic [PIX-1:0] m);
    start = s; res = r; acq_valid = v; hit_data = d; hit_mask = m;
    @(negedge clk);
    if (chk_en) check_cycle();
    @(posedge clk);
    cyc++;
    model_edge(s, r, v, d, m);
    if (r) chk_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rnd_data(), PIX'($urandom()));
  endtask

  task automatic send_frame(input logic [PIX*NP-1:0] d, input logic [PIX-1:0] m);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1'b0, 1'b0, 1'b1, d, m);
      got = captured;
    end
    check_val("frame_captured", got, 1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; frames = 0;
    idle_from = 0; ready_from = 0; done_cycle = -1; rst_cycle = -1;
    active = 1'b0; chk_en = 1'b0; captured = 1'b0;
    res = 1'b1; start = 1'b0; acq_valid = 1'b0; hit_data = '0; hit_mask = '0;
    fa = '{108, 511, 1022, 1022, 200, 90};
    fb = '{300, 500, 50, 1000, 48, 90};
    fc = '{1, 2, 3, 4, 5, 6};
    fd = '{7, 8, 9, 10, 11, 12};

    // Reset, with start and acq_valid asserted while held
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, rnd_data(), 6'h3f);
    step(1'b1, 1'b1, 1'b1, rnd_data(), 6'h3f);
    idle(3);

    // Full measurement, all pixels; start in the DONE cycle is ignored
    step(1'b1, 1'b0, 1'b0, '0, '0);
    send_frame(pack(fa), 6'b111111);
    send_frame(pack(fb), 6'b111111);
    idle(6);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(4);

    // Masked pixels keep their slots
    step(1'b1, 1'b0, 1'b0, '0, '0);
    send_frame(pack(fc), 6'b101010);
    send_frame(pack(fd), PIX'($urandom()));
    idle(8);

    // acq_valid held high with data changing every cycle
    caps.delete();
    step(1'b1, 1'b0, 1'b1, rnd_data(), 6'h3f);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, rnd_data(), PIX'($urandom()));
    check_val("capture_count", caps.size(), 2);
    if (caps.size() >= 2) check_val("capture_period", caps[1] - caps[0], PIX + 1);
    idle(4);

    // Reset while slot 3 of acquisition 0 is on the output, then a clean restart
    step(1'b1, 1'b0, 1'b0, '0, '0);
    send_frame(pack(fa), 6'h3f);
    idle(4);
    step(1'b0, 1'b1, 1'b0, rnd_data(), 6'h3f);
    idle(3);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    send_frame(pack(fb), 6'h3f);
    send_frame(pack(fa), 6'h3f);
    idle(10);

`ifdef TDC_RANGE_GATE_EN
    // Range gate on frame A
    step(1'b1, 1'b0, 1'b0, '0, '0);
    send_frame(pack(fa), 6'h3f);
    send_frame(pack(fb), 6'h3f);
    idle(10);
`endif

    // Random traffic, including a two-cycle reset in the middle
    for (int i = 0; i < 1500; i++) begin
      bit r;
      r = (i == 700) || (i == 701) || ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 5) == 0, r, $urandom_range(0, 2) == 0, rnd_data(), PIX'($urandom()));
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
